// File: rtl/ureg_pkg.sv
// Shared definitions for the universal bus register: the mode command encoding
// used by the register and by the control decoder that drives it.
package ureg_pkg;

    typedef enum logic [2:0] {
        UREG_HOLD = 3'd0,
        UREG_LOAD = 3'd1,
        UREG_INC  = 3'd2,
        UREG_DEC  = 3'd3,
        UREG_SHL  = 3'd4,
        UREG_SHR  = 3'd5,
        UREG_ROL  = 3'd6,
        UREG_ROR  = 3'd7
    } ureg_mode_e;

endpackage

// File: rtl/univ_register_if.sv
// Control and status bundle of the universal register. The shared data bus is
// a tristate net and stays a plain inout port on the register itself.
interface univ_register_if #(
    parameter int N = 8
);
    import ureg_pkg::*;

    logic         en_;
    logic         o_;
    logic         clr;
    ureg_mode_e   mode;
    logic         sin;
    logic [N-1:0] q;
    logic         co;
    logic         zf;

    modport master (
        output en_, o_, clr, mode, sin,
        input  q, co, zf
    );

    modport slave (
        input  en_, o_, clr, mode, sin,
        output q, co, zf
    );

endinterface

// File: rtl/ureg_next.sv
// Combinational next value and next carry of the universal register for each
// mode command; HOLD passes the current carry through unchanged.
module ureg_next
    import ureg_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [N-1:0] q,
    input  logic         co,
    input  ureg_mode_e   mode,
    input  logic         sin,
    input  logic [N-1:0] bus,
    output logic [N-1:0] q_next,
    output logic         co_next
);

    always_comb begin
        q_next  = q;
        co_next = co;
        unique case (mode)
            UREG_HOLD: begin
                q_next  = q;
                co_next = co;
            end
            UREG_LOAD: begin
                q_next  = bus;
                co_next = 1'b0;
            end
            UREG_INC: begin
                q_next  = q + N'(1);
                co_next = &q;
            end
            UREG_DEC: begin
                q_next  = q - N'(1);
                co_next = (q == '0);
            end
            UREG_SHL: begin
                q_next  = {q[N-2:0], sin};
                co_next = q[N-1];
            end
            UREG_SHR: begin
                q_next  = {sin, q[N-1:1]};
                co_next = q[0];
            end
            UREG_ROL: begin
                q_next  = {q[N-2:0], q[N-1]};
                co_next = q[N-1];
            end
            UREG_ROR: begin
                q_next  = {q[0], q[N-1:1]};
                co_next = q[0];
            end
            default: begin
                q_next  = q;
                co_next = co;
            end
        endcase
    end

endmodule

// File: rtl/univ_register.sv
// Universal bus register: N-bit store with load/inc/dec/shift/rotate, a
// registered carry flag, a combinational zero flag and a tristate bus driver.
module univ_register
    import ureg_pkg::*;
#(
    parameter int           N         = 8,
    parameter logic [N-1:0] RESET_VAL = '0
) (
    input  logic               clk,
    input  logic               reset,
    inout  wire  [N-1:0]       bus,
    univ_register_if.slave     ctl
);

    logic [N-1:0] q_reg;
    logic         co_reg;
    logic [N-1:0] q_next;
    logic         co_next;

    ureg_next #(.N(N)) u_next (
        .q       (q_reg),
        .co      (co_reg),
        .mode    (ctl.mode),
        .sin     (ctl.sin),
        .bus     (bus),
        .q_next  (q_next),
        .co_next (co_next)
    );

    // clr beats the enable, which beats the mode command
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_reg  <= RESET_VAL;
            co_reg <= 1'b0;
        end else if (ctl.clr) begin
            q_reg  <= '0;
            co_reg <= 1'b0;
        end else if (!ctl.en_) begin
            q_reg  <= q_next;
            co_reg <= co_next;
        end
    end

    assign bus    = ctl.o_ ? 'z : q_reg;
    assign ctl.q  = q_reg;
    assign ctl.co = co_reg;
    assign ctl.zf = (q_reg == '0);

endmodule
